gen_add_seq: RTL and testbench
==============================

// Module: gen_add_seq
// PURPOSE
//  Sequencer wrapped around the N-bit ripple-carry adder gen_add. Adds two WORDS*N-bit
//  operands one N-bit slice per clock, least significant slice first, and registers the
//  carry between slices. Upstream and downstream both use valid/ready handshakes, so wide
//  adds reuse a single narrow adder instance.
// PARAMETERS
//  N      4   slice width; passed to the gen_add instance.
//  WORDS  4   number of slices; W = N*WORDS is the operand width (WORDS >= 1).
// PORTS
//  clk        in   1   single clock; all state changes on the rising edge.
//  rst_n      in   1   asynchronous, active-low reset.
//  in_valid   in   1   operands valid.
//  in_ready   out  1   block can accept operands.
//  a          in   W   operand A; sampled only on an input handshake.
//  b          in   W   operand B; sampled only on an input handshake.
//  carry_in   in   1   carry into slice 0; sampled with a/b.
//  out_valid  out  1   sum and carry_out valid.
//  out_ready  in   1   consumer accepts the result.
//  sum        out  W   registered result.
//  carry_out  out  1   registered carry out of the top slice.
//  busy       out  1   high in RUN.
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, idx=0, carry_r=0, a_r=b_r=0, sum=0, carry_out=0, out_valid=0, busy=0.
//   - in_ready=1 (IDLE).
//  Handshake rules:
//   - An input handshake occurs when in_valid & in_ready; an output handshake when out_valid & out_ready.
//   - in_ready = (state==IDLE) | (state==DONE & out_ready).
//   - out_valid = (state==DONE).
//  FSM states:
//   - IDLE: on an input handshake, latch a_r=a, b_r=b, carry_r=carry_in, idx=0, then go to RUN.
//   - RUN: feed slice idx of a_r and b_r, plus carry_r, into gen_add.
//     Each cycle write the adder sum into sum[idx*N +: N] and set carry_r to the adder carry.
//     If idx==WORDS-1, set carry_out to the adder carry, set idx=0 and go to DONE; else idx+1.
//   - DONE: hold sum and carry_out stable. On an output handshake:
//     - with a simultaneous input handshake: latch the new operands and go to RUN (back-to-back);
//     - otherwise go to IDLE.
//  Timing and width rules:
//   - Latency: out_valid rises exactly WORDS cycles after the input-handshake edge.
//   - Minimum issue interval is WORDS+1 cycles (back-to-back).
//   - Arithmetic: {carry_out,sum} = a + b + carry_in, modulo 2^(W+1); no saturation.
//   - idx is max(1,$clog2(WORDS)) bits wide and never exceeds WORDS-1.
//  Boundary conditions:
//   - in_valid while in RUN, or in DONE with out_ready=0: operands are not taken, no state change.
//   - out_ready while not in DONE: ignored.
//   - sum is only partially updated during RUN; consumers may read it only while out_valid=1.
//   - Reset mid-RUN or mid-DONE: the operation is discarded, all registers return to reset
//     values, and no stale carry reaches the next operation.
//   - WORDS=1: RUN lasts one cycle, and the block behaves as a registered gen_add.
// STRUCTURE
//  - Shared package gen_add_seq_pkg holds the state encoding localparams:
//    IDLE=2'b00, RUN=2'b01, DONE=2'b10 (2'b11 is illegal and recovers to IDLE).
//  - One sub-module: gen_add #(.N(N)), instantiated once and fed by the idx slice muxes.
//  - Everything else stays in this module: FSM, idx counter, operand/sum/carry registers.
// TESTING  (N=4, WORDS=4, W=16)
//  1. a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0; out_valid 4 cycles after accept.
//  2. a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1 (carry crosses all 4 slices).
//  3. a=16'h8000, b=16'h8000, cin=0 -> sum=16'h0000, cout=1; then a=16'h0001, b=16'h0001, cin=0 -> 16'h0002, cout=0 (no carry leak).
//  4. Result pending, out_ready=0 for 5 cycles with in_valid=1 -> out_valid, sum and cout stable; in_ready=0; nothing accepted.
//  5. DONE with out_ready=1 and in_valid=1 carrying a=16'h00FF, b=16'h0001 -> both handshakes in one cycle; next result 16'h0100 after 4 cycles.
//  6. rst_n pulsed low while idx=2 in RUN -> out_valid=0, sum=0, in_ready=1; a following 16'h0F0F+16'h0101 gives 16'h1010, cout=0.

Source files
------------

// File: rtl/gen_add_seq_pkg.sv
// Shared definitions for the slice-serial adder sequencer: FSM state encoding.
package gen_add_seq_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Width of the slice index; never narrower than one bit so WORDS=1 still has a register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/gen_add.sv
// N-bit ripple-carry adder; purely combinational.
module gen_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/gen_add_seq.sv
// Adds two WORDS*N-bit operands one N-bit slice per clock through a single gen_add,
// least significant slice first, with the inter-slice carry held in a register.
module gen_add_seq
    import gen_add_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high in IDLE, and in DONE when the result is being taken that cycle.
    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_r, b_r;
    logic          carry_r;
    logic [N-1:0]  slice_a, slice_b, slice_s;
    logic          slice_co;
    logic          in_hs, out_hs;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    assign slice_a = a_r[idx*N +: N];
    assign slice_b = b_r[idx*N +: N];

    gen_add #(.N(N)) u_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_r),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= carry_in;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*N +: N] <= slice_s;
                    carry_r         <= slice_co;
                    if (idx == LAST) begin
                        carry_out <= slice_co;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_hs) begin
                        if (in_hs) begin
                            a_r     <= a;
                            b_r     <= b;
                            carry_r <= carry_in;
                            idx     <= '0;
                            state   <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_add_seq.sv
// Directed bench for gen_add_seq with N=4, WORDS=4 (16-bit operands).
module tb_gen_add_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry_out;
    logic        busy;

    int total;
    int bad;

    gen_add_seq #(.N(4), .WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands for one edge; caller guarantees in_ready is high.
    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        carry_in = cv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded to 20.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic collect();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h want 0000", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", carry_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        send(16'h1234, 16'h4321, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_run: got %b want 0", in_ready); end
        wait_done(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
        total++; if (sum !== 16'h5555) begin bad++; $display("FAIL basic_sum: got %h want 5555", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL basic_cout: got %b want 0", carry_out); end
        collect();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_after_collect: got %b want 0", out_valid); end
    endtask

    task automatic test_carry_chain();
        int lat;
        send(16'hFFFF, 16'h0000, 1'b1);
        wait_done(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL chain_latency: got %0d want 4", lat); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL chain_sum: got %h want 0000", sum); end
        total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL chain_cout: got %b want 1", carry_out); end
        collect();
    endtask

    task automatic test_no_leak();
        int lat;
        send(16'h8000, 16'h8000, 1'b0);
        wait_done(lat);
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL top_carry_sum: got %h want 0000", sum); end
        total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL top_carry_cout: got %b want 1", carry_out); end
        collect();
        send(16'h0001, 16'h0001, 1'b0);
        wait_done(lat);
        total++; if (sum !== 16'h0002) begin bad++; $display("FAIL no_leak_sum: got %h want 0002", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL no_leak_cout: got %b want 0", carry_out); end
        collect();
    endtask

    task automatic test_out_ready_idle();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_ready_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_out_ready_busy: got %b want 0", busy); end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int lat;
        send(16'h0A0B, 16'h0102, 1'b1);
        wait_done(lat);
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        carry_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
            total++; if (sum !== 16'h0B0E) begin bad++; $display("FAIL stall_sum[%0d]: got %h want 0b0e", i, sum); end
            total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL stall_cout[%0d]: got %b want 0", i, carry_out); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        collect();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_not_taken: busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        send(16'h0001, 16'h0002, 1'b0);
        wait_done(lat);
        total++; if (sum !== 16'h0003) begin bad++; $display("FAIL b2b_first_sum: got %h want 0003", sum); end
        in_valid  = 1'b1;
        a         = 16'h00FF;
        b         = 16'h0001;
        carry_in  = 1'b0;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
        wait_done(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL b2b_latency: got %0d want 4", lat); end
        total++; if (sum !== 16'h0100) begin bad++; $display("FAIL b2b_sum: got %h want 0100", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL b2b_cout: got %b want 0", carry_out); end
        collect();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        send(16'hFFFF, 16'h0001, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrun_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_rst_valid: got %b want 0", out_valid); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL midrun_rst_sum: got %h want 0000", sum); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrun_rst_in_ready: got %b want 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_rst_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0F0F, 16'h0101, 1'b0);
        wait_done(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL post_rst_latency: got %0d want 4", lat); end
        total++; if (sum !== 16'h1010) begin bad++; $display("FAIL post_rst_sum: got %h want 1010", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL post_rst_cout: got %b want 0", carry_out); end
        collect();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_no_leak();
        test_out_ready_idle();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
